// File: rtl/fifo_burst_wr_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO write port between NUM_REQ producers.
// Words are written as {source id, payload}; a burst is admitted only if MAX_BURST words fit.
module fifo_burst_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 62,
  parameter int DATA_DEPTH = 9,
  parameter int CNT_WIDTH  = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_din,
  output logic                           fifo_wr_en,
  input  logic                           fifo_full,
  input  logic [CNT_WIDTH:0]             fifo_data_count,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy,
  output logic                           burst_err
);
  // state | meaning
  // IDLE  | no owner; admission check and round-robin pick from rr_ptr
  // BURST | grant_id owns the write port until last or MAX_BURST beats

  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam int FW  = CNT_WIDTH + 2;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0]   grant_nxt, pick_id, grant_inc;
  logic [BCW-1:0]        beat_cnt, beat_cnt_nxt;
  logic                  burst_err_nxt;
  logic                  pick_vld, admit, xfer;
  logic                  cur_valid, cur_last;
  logic [FW-1:0]         free;
  logic [DATA_WIDTH-1:0] cur_data;

  assign free      = FW'(2**DATA_DEPTH) - FW'(fifo_data_count);
  assign admit     = (free >= FW'(MAX_BURST));
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign grant_inc = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    beat_cnt_nxt  = beat_cnt;
    burst_err_nxt = 1'b0;
    req_ready     = '0;
    xfer          = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = {grant_id, cur_data};
    busy          = (state == BURST);
    case (state)
      IDLE: begin
        if (pick_vld && admit) begin
          grant_nxt    = pick_id;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id] = ~fifo_full;
        xfer                = cur_valid & ~fifo_full;
        fifo_wr_en          = xfer;
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          // A missing last after MAX_BURST beats is cut off and flagged.
          if (cur_last || (beat_cnt == BCW'(MAX_BURST-1))) begin
            state_nxt     = IDLE;
            rr_ptr_nxt    = grant_inc;
            burst_err_nxt = ~cur_last;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_nxt;
      beat_cnt  <= beat_cnt_nxt;
      burst_err <= burst_err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_wr_arbiter.sv
// Self-checking bench for fifo_burst_wr_arbiter: behavioural arbiter model, per-producer
// sequence scoreboard, emulated FIFO occupancy, directed scenarios and a randomized phase.
module tb_fifo_burst_wr_arbiter;
  localparam int NUM_REQ = 4, ID_WIDTH = 2, DATA_WIDTH = 62;
  localparam int DATA_DEPTH = 9, CNT_WIDTH = 9, MAX_BURST = 16;
  localparam int CAP = 1 << DATA_DEPTH;
  localparam int WW  = DATA_WIDTH + ID_WIDTH;

  logic                          clk = 1'b0;
  logic                          srst;
  logic [NUM_REQ-1:0]            req_valid, req_last, req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [WW-1:0]                 fifo_din;
  logic                          fifo_wr_en, fifo_full, busy, burst_err;
  logic [CNT_WIDTH:0]            fifo_data_count;
  logic [ID_WIDTH-1:0]           grant_id;

  fifo_burst_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH), .CNT_WIDTH(CNT_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_data_count(fifo_data_count),
    .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  // producer and FIFO stimulus controls
  int unsigned p_seq [NUM_REQ];
  int          p_len [NUM_REQ];
  int          p_reload [NUM_REQ];
  int          p_rlen [NUM_REQ];
  int          bubble = 0, drain_pct = 100, occ = 0, f_cnt = 0;
  logic        f_full = 1'b0, f_cnt_en = 1'b0, ctl_srst = 1'b1, chk_en = 1'b0;

  // observations
  logic [NUM_REQ-1:0] hs = '0;
  logic               w_seen = 1'b0;
  logic               prev_busy = 1'b0;
  int unsigned        w_seq [NUM_REQ];
  int                 wcnt [NUM_REQ];
  int                 dut_grants[$];
  int                 dut_gcyc[$];
  int                 err_pulses = 0;

  // behavioural model
  bit m_busy = 1'b0, m_err = 1'b0;
  int m_gid = 0, m_ptr = 0, m_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int  c;
    bit  found;
    if (srst) begin
      m_busy = 1'b0; m_err = 1'b0; m_gid = 0; m_ptr = 0; m_beats = 0;
    end else begin
      m_err = 1'b0;
      if (!m_busy) begin
        if ((req_valid != '0) && ((CAP - int'(fifo_data_count)) >= MAX_BURST)) begin
          found = 1'b0;
          for (int k = 0; k < NUM_REQ; k++) begin
            c = (m_ptr + k) % NUM_REQ;
            if (!found && req_valid[c]) begin
              found = 1'b1;
              m_gid = c;
            end
          end
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end else if (req_valid[m_gid] && !fifo_full) begin
        m_beats++;
        if (req_last[m_gid] || m_beats == MAX_BURST) begin
          m_busy = 1'b0;
          m_ptr  = (m_gid + 1) % NUM_REQ;
          m_err  = !req_last[m_gid];
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] er;
    logic               ewr;
    logic [WW-1:0]      ed;
    int                 id;
    hs     = req_valid & req_ready;
    w_seen = fifo_wr_en;
    if (chk_en) begin
      er = '0;
      if (m_busy && !fifo_full) er[m_gid] = 1'b1;
      ewr = m_busy && req_valid[m_gid] && !fifo_full;
      check("req_ready", 64'(req_ready), 64'(er));
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(ewr));
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("burst_err", 64'(burst_err), 64'(m_err));
      if (ewr) begin
        ed = {ID_WIDTH'(m_gid), req_data[m_gid*DATA_WIDTH +: DATA_WIDTH]};
        check("fifo_din", fifo_din, ed);
      end
      if (fifo_wr_en === 1'b1) begin
        id = int'(fifo_din[WW-1 -: ID_WIDTH]);
        check("order_seq", 64'(fifo_din[31:0]), 64'(w_seq[id]));
        check("order_tag", 64'(fifo_din[47:40]), 64'(id));
        w_seq[id] = fifo_din[31:0] + 1;
        wcnt[id]++;
      end
      if (busy && !prev_busy) begin
        dut_grants.push_back(int'(grant_id));
        dut_gcyc.push_back(cyc);
      end
      if (burst_err === 1'b1) err_pulses++;
      prev_busy = busy;
    end
  end

  task automatic drive();
    logic [DATA_WIDTH-1:0] d;
    srst            = ctl_srst;
    fifo_full       = f_full || (occ >= CAP);
    fifo_data_count = f_cnt_en ? (CNT_WIDTH+1)'(f_cnt) : (CNT_WIDTH+1)'(occ);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (p_len[i] > 0) && (int'($urandom_range(99)) >= bubble);
      req_last[i]  = (p_len[i] == 1);
      d            = '0;
      d[47:40]     = 8'(i);
      d[31:0]      = p_seq[i];
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (w_seen) occ++;
    if (occ > 0 && int'($urandom_range(99)) < drain_pct) occ--;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        p_seq[i]++;
        p_len[i]--;
        if (p_len[i] == 0 && p_reload[i] > 0) begin
          p_reload[i]--;
          p_len[i] = (p_rlen[i] != 0) ? p_rlen[i] : int'($urandom_range(20, 1));
        end
      end
    end
    drive();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NUM_REQ; i++) if (p_len[i] != 0) return 1'b0;
    return (busy === 1'b0);
  endfunction

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin
      step();
      n++;
    end
    check(name, 64'(n < maxc), 64'(1));
  endtask

  task automatic do_reset();
    ctl_srst = 1'b1;
    step();
    step();
    ctl_srst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, e0;
    int c0 [NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) begin
      p_seq[i] = (i == 2) ? 32'h10 : 32'h0;
      w_seq[i] = p_seq[i];
      p_len[i] = 0; p_reload[i] = 0; p_rlen[i] = 0; wcnt[i] = 0;
    end
    drive();
    step();
    chk_en = 1'b1;
    step();
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(burst_err), 64'(0));
    check("rst_gid", 64'(grant_id), 64'(0));
    ctl_srst = 1'b0;
    step();

    // producer 2, 4-beat burst 0x10..0x13
    p_len[2] = 4;
    step(); #1;
    check("t1_idle_ready", 64'(req_ready), 64'(0));
    step(); #1;
    check("t1_ready", 64'(req_ready), 64'(4'b0100));
    check("t1_gid", 64'(grant_id), 64'(2));
    wait_idle("t1_done", 50);
    check("t1_writes", 64'(wcnt[2]), 64'(4));
    check("t1_next_seq", 64'(w_seq[2]), 64'(32'h14));

    // all producers with 2-beat bursts, producer 0 twice
    do_reset();
    base = dut_grants.size();
    for (int i = 0; i < NUM_REQ; i++) begin
      c0[i] = wcnt[i]; p_len[i] = 2; p_rlen[i] = 2;
    end
    p_reload[0] = 1;
    wait_idle("t2_done", 100);
    check("t2_ngrants", 64'(dut_grants.size() - base), 64'(5));
    if (dut_grants.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) check("t2_order", 64'(dut_grants[base+k]), 64'(k % NUM_REQ));
      for (int k = 1; k < 5; k++) check("t2_gap", 64'(dut_gcyc[base+k] - dut_gcyc[base+k-1]), 64'(3));
    end
    check("t2_w0", 64'(wcnt[0] - c0[0]), 64'(4));
    for (int i = 1; i < NUM_REQ; i++) check("t2_wn", 64'(wcnt[i] - c0[i]), 64'(2));

    // admission threshold: 497 blocks, 496 admits
    f_cnt_en = 1'b1; f_cnt = 497; p_len[1] = 2;
    repeat (4) begin
      step(); #1;
      check("t3_no_grant", 64'(busy), 64'(0));
    end
    f_cnt = 496;
    step(); #1;
    check("t3_idle", 64'(busy), 64'(0));
    step(); #1;
    check("t3_grant", 64'(busy), 64'(1));
    check("t3_gid", 64'(grant_id), 64'(1));
    wait_idle("t3_done", 50);
    f_cnt_en = 1'b0;

    // producer 0 overruns MAX_BURST while others wait
    do_reset();
    base = dut_grants.size(); e0 = err_pulses; c0[0] = wcnt[0];
    p_len[0] = 20;
    for (int i = 1; i < NUM_REQ; i++) p_len[i] = 2;
    wait_idle("t4_done", 200);
    check("t4_err_pulses", 64'(err_pulses - e0), 64'(1));
    check("t4_ngrants", 64'(dut_grants.size() - base), 64'(5));
    if (dut_grants.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) check("t4_order", 64'(dut_grants[base+k]), 64'(k % NUM_REQ));
      check("t4_first_len", 64'(dut_gcyc[base+1] - dut_gcyc[base]), 64'(MAX_BURST + 1));
    end
    check("t4_w0", 64'(wcnt[0] - c0[0]), 64'(20));

    // fifo_full for 3 cycles mid-burst
    c0[1] = wcnt[1];
    p_len[1] = 8;
    repeat (4) step();
    f_full = 1'b1;
    repeat (3) begin
      step(); #1;
      check("t5_full_ready", 64'(req_ready), 64'(0));
      check("t5_full_wr", 64'(fifo_wr_en), 64'(0));
    end
    f_full = 1'b0;
    step(); #1;
    check("t5_resume", 64'(req_ready), 64'(4'b0010));
    wait_idle("t5_done", 50);
    check("t5_w1", 64'(wcnt[1] - c0[1]), 64'(8));

    // srst at beat 3 of an 8-beat burst from producer 2
    c0[2] = wcnt[2];
    p_len[2] = 8;
    repeat (3) step();
    ctl_srst = 1'b1;
    step(); #1;
    check("t6_beat3", 64'(fifo_wr_en), 64'(1));
    ctl_srst = 1'b0;
    p_len[0] = 2;
    step(); #1;
    check("t6_rst_ready", 64'(req_ready), 64'(0));
    check("t6_rst_wr", 64'(fifo_wr_en), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_err", 64'(burst_err), 64'(0));
    check("t6_rst_gid", 64'(grant_id), 64'(0));
    step(); #1;
    check("t6_first", 64'(busy), 64'(1));
    check("t6_first_gid", 64'(grant_id), 64'(0));
    wait_idle("t6_done", 100);
    check("t6_w2", 64'(wcnt[2] - c0[2]), 64'(8));

    // randomized traffic with emulated FIFO drain and sporadic full
    do_reset();
    bubble = 20; drain_pct = 55;
    for (int i = 0; i < NUM_REQ; i++) begin
      p_rlen[i] = 0; p_reload[i] = 1000; p_len[i] = int'($urandom_range(20, 1));
    end
    repeat (3000) begin
      f_full = (int'($urandom_range(99)) < 4);
      step();
    end
    for (int i = 0; i < NUM_REQ; i++) p_reload[i] = 0;
    f_full = 1'b0; drain_pct = 100; bubble = 0;
    wait_idle("t7_drain", 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_burst_wr_arbiter.md
Name: fifo_burst_wr_arbiter

Overview:
- Round-robin write arbiter that shares one para_sync_fifo_ST instance between NUM_REQ independent producers.
- Grants the FIFO write port to one producer for a whole burst, terminated by a last flag.
- Grants only when the FIFO has room for a maximum-length burst, so an admitted burst never stalls on full under nominal operation.
- Tags every written word with the source ID so the consumer can demultiplex.

Parameters:
- NUM_REQ, 4: number of producers.
- ID_WIDTH, 2: source-ID width; must satisfy 2^ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 62: producer payload width; FIFO word width = DATA_WIDTH + ID_WIDTH (64).
- DATA_DEPTH, 9: FIFO address width; capacity 2^DATA_DEPTH = 512.
- CNT_WIDTH, 9: FIFO data_count is CNT_WIDTH+1 bits.
- MAX_BURST, 16: maximum beats per grant; admission threshold.

Ports:
- clk, input, 1: clock.
- srst, input, 1: synchronous reset, active-high.
- req_valid, input, NUM_REQ: per-producer beat valid.
- req_last, input, NUM_REQ: per-producer last beat of burst.
- req_data, input, NUM_REQ*DATA_WIDTH: payloads; producer i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, output, NUM_REQ: per-producer beat accepted.
- fifo_din, output, DATA_WIDTH+ID_WIDTH: {grant_id, payload} to FIFO din.
- fifo_wr_en, output, 1: FIFO write enable.
- fifo_full, input, 1: FIFO full.
- fifo_data_count, input, CNT_WIDTH+1: FIFO occupancy.
- grant_id, output, ID_WIDTH: currently or last granted producer.
- busy, output, 1: high in state BURST.
- burst_err, output, 1: one-cycle pulse on forced burst termination.

Behaviour:
- Reset:
  - srst sampled on the clk edge; state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0.
  - All outputs 0: req_ready, fifo_wr_en, busy, burst_err.
- Free space: free = 2^DATA_DEPTH - fifo_data_count, computed at CNT_WIDTH+2 bits; admit = (free >= MAX_BURST).
- State IDLE:
  - req_ready = 0.
  - If any req_valid and admit: pick the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ. Register grant_id to it, clear beat_cnt, go to BURST on the next edge.
  - Otherwise stay in IDLE.
- IDLE minimum dwell: IDLE always lasts at least 1 cycle between bursts, so fifo_data_count reflects the final write before the next admission check.
- State BURST:
  - req_ready[grant_id] = ~fifo_full; all other req_ready = 0.
  - A beat transfers when req_valid[g] && req_ready[g]. Then fifo_wr_en = 1 in the same cycle (combinational) and fifo_din = {grant_id, req_data[g]}.
  - Each transfer increments beat_cnt.
  - Transfer with req_last[g] = 1: go to IDLE, rr_ptr <= grant_id + 1 (wraps to 0 after NUM_REQ-1).
  - Transfer that is beat MAX_BURST without last (beat_cnt == MAX_BURST-1 at transfer): go to IDLE, burst_err pulses for 1 cycle on the next cycle, rr_ptr advances as above.
  - Bubbles (req_valid[g] = 0) hold BURST indefinitely; no timeout.
- Latency:
  - Request visible in IDLE at cycle N gives req_ready high at cycle N+1.
  - Back-to-back beats sustain 1 word per clk.
  - Minimum gap between bursts is 1 IDLE cycle.
- fifo_full during BURST: req_ready deasserts the same cycle and no write is issued. Never drive fifo_wr_en while fifo_full = 1.
- req_last outside BURST, or on a non-granted port, is ignored.
- Reset mid-burst: return to IDLE at the next edge. The partially written burst stays in the FIFO; no cleanup.
- grant_id holds its value in IDLE until the next grant.

Test Plan:
- Reset, then producer 2 issues a 4-beat burst with payloads 0x10..0x13. Required: req_ready[2] high from the cycle after first valid, 4 FIFO writes with fifo_din[63:62] = 2, return to IDLE.
- All 4 producers continuously request 2-beat bursts. Required: grant order 0,1,2,3,0, each separated by exactly 1 IDLE cycle, 8 writes per round.
- fifo_data_count = 497 (free 15) with producer 1 valid. Required: no grant. Drop count to 496: grant issued the next cycle.
- Producer 0 sends 16 beats without last. Required: 16 writes, burst_err high exactly 1 cycle, then producer 0 with valid still high is granted only after the other pending requesters.
- fifo_full forced high for 3 cycles mid-burst. Required: req_ready and fifo_wr_en low for those 3 cycles, no beat lost or duplicated, data order preserved.
- srst asserted at beat 3 of an 8-beat burst. Required: next cycle all outputs 0, rr_ptr = 0, and producer 0 is granted first afterwards.
